// File: rtl/sincos_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 17-bit sine/cosine core between NREQ requesters.
// Angles are registered in front of the core (S1) and results behind it (S2), with valid/ready backpressure.

module fix_sin_cos_poly (
    input  logic [16:0] x_i,
    output logic [16:0] s_o,
    output logic [16:0] c_o
);
    // x_i is a two's complement angle in units of pi/65536; outputs are scaled by 32768.
    // Quadrant comes from x_i[16:15]; the residual x_i[14:0] spans [0, pi/2) as a Q15 fraction.
    localparam logic signed [31:0] KS1 = 32'sd51472;
    localparam logic signed [31:0] KS3 = 32'sd21167;
    localparam logic signed [31:0] KS5 = 32'sd2611;
    localparam logic signed [31:0] KS7 = 32'sd153;
    localparam logic signed [31:0] KC0 = 32'sd32768;
    localparam logic signed [31:0] KC2 = 32'sd40426;
    localparam logic signed [31:0] KC4 = 32'sd8312;
    localparam logic signed [31:0] KC6 = 32'sd684;
    localparam logic signed [31:0] KC8 = 32'sd30;

    logic signed [31:0] t_s, t2_s;
    logic signed [31:0] ps5_s, ps3_s, ps1_s;
    logic signed [31:0] pc6_s, pc4_s, pc2_s;
    logic signed [16:0] sin_r_s, cos_r_s;

    // Horner-form odd/even polynomials on the residual, then quadrant rotation
    always_comb begin
        t_s     = $signed({17'd0, x_i[14:0]});
        t2_s    = (t_s * t_s) >>> 15;
        ps5_s   = KS5 - ((KS7 * t2_s) >>> 15);
        ps3_s   = KS3 - ((ps5_s * t2_s) >>> 15);
        ps1_s   = KS1 - ((ps3_s * t2_s) >>> 15);
        sin_r_s = 17'((ps1_s * t_s) >>> 15);
        pc6_s   = KC6 - ((KC8 * t2_s) >>> 15);
        pc4_s   = KC4 - ((pc6_s * t2_s) >>> 15);
        pc2_s   = KC2 - ((pc4_s * t2_s) >>> 15);
        cos_r_s = 17'(KC0 - ((pc2_s * t2_s) >>> 15));
        case (x_i[16:15])
            2'b00: begin
                s_o = sin_r_s;
                c_o = cos_r_s;
            end
            2'b01: begin
                s_o = cos_r_s;
                c_o = -sin_r_s;
            end
            2'b10: begin
                s_o = -sin_r_s;
                c_o = -cos_r_s;
            end
            default: begin
                s_o = -cos_r_s;
                c_o = sin_r_s;
            end
        endcase
    end
endmodule

module sincos_rr_scheduler #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*17-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [16:0]          out_s,
    output logic [16:0]          out_c,
    output logic                 busy
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [16:0]     s1_x_q, s1_x_d;
    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic [16:0]     out_s_q, out_s_d;
    logic [16:0]     out_c_q, out_c_d;
    logic            busy_q, busy_d;

    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] idx_s, winner_s;
    logic            found_s, hit_s, adv2_s, can_accept_s, grant_s;
    logic [16:0]     win_x_s, core_s_s, core_c_s;

    fix_sin_cos_poly u_core (
        .x_i (s1_x_q),
        .s_o (core_s_s),
        .c_o (core_c_s)
    );

    // Round-robin search from ptr, wrapping at NREQ (not at 2^ID_W)
    always_comb begin
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        sum_s    = {(ID_W+1){1'b0}};
        idx_s    = {ID_W{1'b0}};
        hit_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s    = {1'b0, ptr_q} + (ID_W+1)'(k);
            idx_s    = (sum_s >= (ID_W+1)'(NREQ)) ? ID_W'(sum_s - (ID_W+1)'(NREQ)) : sum_s[ID_W-1:0];
            hit_s    = !found_s && req_valid[idx_s];
            winner_s = hit_s ? idx_s : winner_s;
            found_s  = found_s || hit_s;
        end
    end

    // Grant qualification and one-hot ready; rst_n gates ready so nothing is offered in reset
    always_comb begin
        adv2_s       = s1_valid_q && (!out_valid_q || out_ready);
        can_accept_s = !s1_valid_q || adv2_s;
        grant_s      = rst_n && found_s && can_accept_s;
        req_ready    = {NREQ{1'b0}};
        win_x_s      = 17'd0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_s && (winner_s == ID_W'(i));
            win_x_s      = (winner_s == ID_W'(i)) ? req_x[i*17 +: 17] : win_x_s;
        end
    end

    // Next state for pointer and both pipeline stages
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_x_d      = s1_x_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_s_d     = out_s_q;
        out_c_d     = out_c_q;
        if (grant_s) begin
            s1_valid_d = 1'b1;
            s1_id_d    = winner_s;
            s1_x_d     = win_x_s;
            ptr_d      = (winner_s == ID_W'(NREQ-1)) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
        end else if (adv2_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (adv2_s) begin
            out_valid_d = 1'b1;
            out_id_d    = s1_id_q;
            out_s_d     = core_s_s;
            out_c_d     = core_c_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        busy_d = s1_valid_d || out_valid_d;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= {ID_W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_id_q     <= {ID_W{1'b0}};
            s1_x_q      <= 17'd0;
            out_valid_q <= 1'b0;
            out_id_q    <= {ID_W{1'b0}};
            out_s_q     <= 17'd0;
            out_c_q     <= 17'd0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_x_q      <= s1_x_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_s_q     <= out_s_d;
            out_c_q     <= out_c_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_s     = out_s_q;
    assign out_c     = out_c_q;
    assign busy      = busy_q;
endmodule

// File: doc/sincos_rr_scheduler.md
# sincos_rr_scheduler

Shares one combinational 17-bit sine/cosine core (FixSinCosPoly) between NREQ independent requesters. Arbitration is round-robin. The block registers each granted angle in front of the core and registers the core result behind it. Each result comes out with the requester ID on a single valid/ready output port, and backpressure stalls the pipeline. The block sits between phase-generating clients (NCOs, rotators) and the shared trig core, so only one core instance is needed per cluster.

## Interface
- NREQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NREQ): width of the ID field. Derived; never overridden.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  NREQ*17  packed angles; requester i uses bits [17*i+16 : 17*i]; same fixed-point format as the core input X.
- req_ready  out  NREQ  one-hot grant; requester i's request is accepted when req_valid[i] && req_ready[i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_id  out  ID_W  index of the requester that owns the result.
- out_s  out  17  sine result, two's complement, core format.
- out_c  out  17  cosine result, two's complement, core format.
- busy  out  1  at least one pipeline stage is occupied.

## Operation
- Two registered stages. S1 holds {s1_valid, s1_id, s1_x}. The core is driven from s1_x. S2 holds {out_valid, out_id, out_s, out_c}, captured from the core outputs.
- Advance conditions:
  - adv2 = s1_valid && (!out_valid || out_ready).
  - can_accept = !s1_valid || adv2.
- Arbitration:
  - Pointer ptr (ID_W bits) is the highest-priority index.
  - The winner is the first i with req_valid[i] set, searching ptr, ptr+1, ... with wrap modulo NREQ (wrap at NREQ, not at 2^ID_W).
  - req_ready[winner] = can_accept. All other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr and the stall state. It never depends on req_x.
  - On an accepted grant, ptr <= (winner+1) mod NREQ. With no grant, ptr holds.
- S1 update:
  - On a grant: s1_valid <= 1, s1_id <= winner, s1_x <= req_x slice of winner.
  - Else if adv2: s1_valid <= 0.
  - Else: S1 holds.
- S2 update:
  - On adv2: out_valid <= 1 and out_id/out_s/out_c <= s1_id/core S/core C.
  - Else if out_valid && out_ready: out_valid <= 0.
  - Else: S2 holds.
- Stall: while out_valid && !out_ready, out_id/out_s/out_c stay stable. S1 holds if it is full. All req_ready bits are 0 if S1 is full.
- No reordering. Results leave in grant order. The core is not modified or truncated: out_s and out_c equal the core outputs bit-for-bit.
- busy = s1_valid || out_valid.
- Requester rule: once req_valid[i] is raised it stays high with req_x stable until accepted. The scheduler does not check this.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - s1_valid = 0, out_valid = 0, out_id = 0, out_s = 0, out_c = 0.
  - ptr = 0, busy = 0, req_ready = all 0.
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1 (one cycle from S1 to output), assuming no stall.
- Throughput: one request per cycle while out_ready is held 1.
- Simultaneous events:
  - Output pop and new grant in the same cycle are allowed. S1 refills as S2 refills.
  - With all requesters valid and no stall, grants rotate 0,1,2,3,0,...
- Full stall: with both stages full and out_ready = 0, nothing moves. When out_ready returns to 1, S1 advances and a new grant is possible in that same cycle.
- Reset mid-operation: in-flight results are discarded, with no partial output. After reset, arbitration restarts from ptr = 0.

## Test plan
- Reset: hold rst_n = 0 with all req_valid = 1 -> req_ready = 0, out_valid = 0, busy = 0. Release reset -> first grant goes to requester 0.
- Single request: requester 2 sends X = 17'h04000 with out_ready = 1 -> accepted in 1 cycle; out_valid rises one cycle later with out_id = 2; out_s/out_c match a standalone core fed 17'h04000.
- Fairness: all 4 valid continuously, out_ready = 1, 12 cycles -> out_id sequence 0,1,2,3 repeated 3 times, one result per cycle.
- Backpressure: stream with out_ready = 0 for 5 cycles -> output held stable, exactly 2 accepted requests in flight, req_ready = 0; out_ready = 1 -> results drain in order, no loss or duplication.
- Sparse requests with wrap: NREQ = 3, ptr = 2, only requesters 0 and 2 valid -> grant order 2,0,2,0.
- Reset mid-stream: assert rst_n = 0 with both stages full -> out_valid drops immediately; after release no stale result appears, and the first new grant goes to requester 0.
